// File: rtl/nnue_feature_sequencer.sv
// Move-descriptor FIFO feeding a three-state sequencer that expands each move
// into NNUE accumulator row add/subtract operations and reports the evaluation.
module nnue_feature_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mv_valid,
  output logic        mv_ready,
  input  logic [5:0]  mv_from,
  input  logic [5:0]  mv_to,
  input  logic        mv_color,
  input  logic        mv_capture,
  input  logic        mv_persp,
  output logic        nn_trigger,
  output logic        nn_player,
  output logic [6:0]  nn_row,
  output logic        nn_add,
  input  logic        nn_finish,
  input  logic [15:0] nn_out,
  output logic        eval_valid,
  output logic [15:0] eval,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef struct packed {
    logic [5:0] from;
    logic [5:0] to;
    logic       color;
    logic       capture;
    logic       persp;
  } move_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  move_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  move_t         head;

  state_t        state, state_nx;
  logic [1:0]    op, op_nx;
  logic          ld, done, null_done, last_op, is_null;

  // Feature row for op index: 0 = own piece leaves 'from', 1 = own piece
  // arrives at 'to', 2 = captured opponent piece leaves 'to'.
  function automatic logic [6:0] op_row(input move_t m, input logic [1:0] idx);
    case (idx)
      2'd0:    op_row = {m.color, m.from};
      2'd1:    op_row = {m.color, m.to};
      default: op_row = {~m.color, m.to};
    endcase
  endfunction

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign mv_ready = ~full;
  assign push     = mv_valid & mv_ready;
  assign head     = mem[rd_ptr];
  assign is_null  = (head.from == head.to);
  assign last_op  = (op == 2'd2) || ((op == 2'd1) && !head.capture);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{from: mv_from, to: mv_to, color: mv_color,
                       capture: mv_capture, persp: mv_persp};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // The head entry stays resident until its last op finishes, so the FSM
  // reads the move straight from the FIFO instead of keeping a private copy.
  always_comb begin
    state_nx  = state;
    op_nx     = op;
    ld        = 1'b0;
    pop       = 1'b0;
    done      = 1'b0;
    null_done = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (is_null) begin
            pop       = 1'b1;
            null_done = 1'b1;
          end else begin
            ld       = 1'b1;
            op_nx    = 2'd0;
            state_nx = ISSUE;
          end
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (nn_finish) begin
          if (last_op) begin
            pop      = 1'b1;
            done     = 1'b1;
            state_nx = IDLE;
          end else begin
            ld       = 1'b1;
            op_nx    = op + 2'd1;
            state_nx = ISSUE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op         <= '0;
      nn_row     <= '0;
      nn_add     <= 1'b0;
      nn_player  <= 1'b0;
      eval       <= '0;
      eval_valid <= 1'b0;
    end else begin
      if (ld) begin
        op        <= op_nx;
        nn_row    <= op_row(head, op_nx);
        nn_add    <= (op_nx == 2'd1);
        nn_player <= head.persp;
      end
      if (done) eval <= nn_out;
      eval_valid <= done | null_done;
    end
  end

  assign nn_trigger = (state == ISSUE);
  assign busy       = (state != IDLE) || !empty;

endmodule

// File: tb/tb_nnue_feature_sequencer.sv
// Scoreboard bench: directed moves push expected row ops / evaluations; a
// negedge monitor pops and compares whenever the DUT triggers or reports.
module tb_nnue_feature_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mv_valid, mv_ready;
  logic [5:0]  mv_from, mv_to;
  logic        mv_color, mv_capture, mv_persp;
  logic        nn_trigger, nn_player, nn_add, nn_finish;
  logic [6:0]  nn_row;
  logic [15:0] nn_out, eval;
  logic        eval_valid, busy;

  always #5 clk = ~clk;

  nnue_feature_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_from(mv_from), .mv_to(mv_to), .mv_color(mv_color),
    .mv_capture(mv_capture), .mv_persp(mv_persp),
    .nn_trigger(nn_trigger), .nn_player(nn_player), .nn_row(nn_row),
    .nn_add(nn_add), .nn_finish(nn_finish), .nn_out(nn_out),
    .eval_valid(eval_valid), .eval(eval), .busy(busy)
  );

  typedef struct {
    logic        is_eval;
    logic [6:0]  row;
    logic        add;
    logic        player;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] outq[$];
  int          total = 0;
  int          bad = 0;
  int          trig_seen = 0;
  int          fin_delay = 5;
  logic        fin_en = 1'b1;
  logic        noise = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic exp_trig(input logic [6:0] row, input logic add, input logic p);
    exp_t e;
    e.is_eval = 1'b0; e.row = row; e.add = add; e.player = p; e.val = '0;
    sb.push_back(e);
  endtask

  task automatic exp_eval(input logic [15:0] v);
    exp_t e;
    e.is_eval = 1'b1; e.row = '0; e.add = 1'b0; e.player = 1'b0; e.val = v;
    sb.push_back(e);
  endtask

  // Returns 1 time unit after the accepting clock edge.
  task automatic push_move(input logic [5:0] f, input logic [5:0] t,
                           input logic c, input logic cap, input logic p);
    int n = 0;
    mv_valid = 1'b1; mv_from = f; mv_to = t;
    mv_color = c; mv_capture = cap; mv_persp = p;
    while (!mv_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready_timeout", {31'd0, mv_ready}, 32'd1);
    @(posedge clk);
    #1 mv_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'd0, busy}, 32'd0);
  endtask

  // NNUE stage model: answers each trigger fin_delay cycles later, popping
  // the next evaluation value; optional noise asserts finish outside WAIT.
  initial begin
    logic pending;
    int   cnt;
    pending = 1'b0; cnt = 0;
    nn_finish = 1'b0; nn_out = 16'h7777;
    forever begin
      @(negedge clk);
      nn_finish = 1'b0;
      nn_out    = 16'h7777;
      if (!rst_n) begin
        pending = 1'b0;
      end else begin
        if (nn_trigger) begin
          pending = 1'b1;
          cnt     = fin_delay;
        end else if (pending) begin
          if (cnt > 0) cnt--;
          if (cnt == 0 && fin_en) begin
            nn_finish = 1'b1;
            nn_out    = (outq.size() != 0) ? outq.pop_front() : 16'hDEAD;
            pending   = 1'b0;
          end
        end
        if (noise && (!pending || nn_trigger)) nn_finish = 1'b1;
      end
    end
  end

  // Monitor: every trigger and every eval_valid consumes one expectation.
  initial begin
    exp_t       e;
    logic       in_op;
    logic [8:0] held;
    in_op = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_op = 1'b0;
      end else begin
        if (nn_trigger) begin
          trig_seen++;
          if (sb.size() != 0) e = sb.pop_front();
          else begin e.is_eval = 1'b1; e.row = '0; e.add = 1'b0; e.player = 1'b0; e.val = '0; end
          chk("trig_expected", {31'd0, e.is_eval}, 32'd0);
          chk("trig_row", {25'd0, nn_row}, {25'd0, e.row});
          chk("trig_add", {31'd0, nn_add}, {31'd0, e.add});
          chk("trig_player", {31'd0, nn_player}, {31'd0, e.player});
          in_op = 1'b1;
          held  = {nn_row, nn_add, nn_player};
        end else if (in_op) begin
          chk("op_stable", {23'd0, nn_row, nn_add, nn_player}, {23'd0, held});
        end
        if (eval_valid) begin
          if (sb.size() != 0) e = sb.pop_front();
          else begin e.is_eval = 1'b0; e.row = '0; e.add = 1'b0; e.player = 1'b0; e.val = '0; end
          chk("eval_expected", {31'd0, e.is_eval}, 32'd1);
          chk("eval_value", {16'd0, eval}, {16'd0, e.val});
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_trigger"}, {31'd0, nn_trigger}, 32'd0);
    chk({tag, "_row_add_player"}, {23'd0, nn_row, nn_add, nn_player}, 32'd0);
    chk({tag, "_eval"}, {15'd0, eval_valid, eval}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ready"}, {31'd0, mv_ready}, 32'd1);
  endtask

  initial begin
    int base, n;
    rst_n = 1'b0; mv_valid = 1'b0; mv_from = '0; mv_to = '0;
    mv_color = 1'b0; mv_capture = 1'b0; mv_persp = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("empty_idle", {30'd0, nn_trigger, busy}, 32'd0);

    // Quiet move: rows 76 (sub), 92 (add), trigger two cycles after accept
    exp_trig(7'd76, 1'b0, 1'b1); exp_trig(7'd92, 1'b1, 1'b1); exp_eval(16'h0042);
    outq.push_back(16'h0017); outq.push_back(16'h0042);
    push_move(6'd12, 6'd28, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("latency_c1", {31'd0, nn_trigger}, 32'd0);
    @(negedge clk);
    chk("latency_c2", {31'd0, nn_trigger}, 32'd1);
    wait_idle();

    // Capture: rows 3 (sub), 59 (add), 123 (sub)
    exp_trig(7'd3, 1'b0, 1'b0); exp_trig(7'd59, 1'b1, 1'b0); exp_trig(7'd123, 1'b0, 1'b0);
    exp_eval(16'h0B0B);
    outq.push_back(16'h0301); outq.push_back(16'h0302); outq.push_back(16'h0B0B);
    push_move(6'd3, 6'd59, 1'b0, 1'b1, 1'b0);
    wait_idle();

    // Null move: no ops, eval_valid two cycles after accept, eval held
    exp_eval(16'h0B0B);
    push_move(6'd7, 6'd7, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("null_c1_valid", {31'd0, eval_valid}, 32'd0);
    @(negedge clk);
    chk("null_c2_valid", {31'd0, eval_valid}, 32'd1);
    chk("null_c2_eval", {16'd0, eval}, 32'h0B0B);
    wait_idle();

    // Spurious finish in IDLE/ISSUE cycles must not advance the op sequence
    noise = 1'b1;
    repeat (3) @(negedge clk);
    exp_trig(7'd97, 1'b0, 1'b0); exp_trig(7'd104, 1'b1, 1'b0); exp_trig(7'd40, 1'b0, 1'b0);
    exp_eval(16'h0A03);
    outq.push_back(16'h0A01); outq.push_back(16'h0A02); outq.push_back(16'h0A03);
    base = trig_seen;
    push_move(6'd33, 6'd40, 1'b1, 1'b1, 1'b0);
    wait_idle();
    chk("noise_trigger_count", trig_seen - base, 32'd3);
    noise = 1'b0;

    // Five back-to-back moves into a 4-deep FIFO with the NNUE stalled
    fin_en = 1'b0; fin_delay = 1;
    exp_trig(7'd1, 1'b0, 1'b0); exp_trig(7'd2, 1'b1, 1'b0); exp_eval(16'h0102);
    exp_trig(7'd74, 1'b0, 1'b1); exp_trig(7'd84, 1'b1, 1'b1); exp_trig(7'd20, 1'b0, 1'b1);
    exp_eval(16'h0203);
    exp_trig(7'd127, 1'b0, 1'b0); exp_trig(7'd64, 1'b1, 1'b0); exp_eval(16'hFFFE);
    exp_eval(16'hFFFE);
    exp_trig(7'd0, 1'b0, 1'b1); exp_trig(7'd63, 1'b1, 1'b1); exp_trig(7'd127, 1'b0, 1'b1);
    exp_eval(16'h1234);
    outq.push_back(16'h0101); outq.push_back(16'h0102);
    outq.push_back(16'h0201); outq.push_back(16'h0202); outq.push_back(16'h0203);
    outq.push_back(16'h0301); outq.push_back(16'hFFFE);
    outq.push_back(16'h8000); outq.push_back(16'h7FFF); outq.push_back(16'h1234);
    push_move(6'd1, 6'd2, 1'b0, 1'b0, 1'b0);
    push_move(6'd10, 6'd20, 1'b1, 1'b1, 1'b1);
    push_move(6'd63, 6'd0, 1'b1, 1'b0, 1'b0);
    push_move(6'd5, 6'd5, 1'b0, 1'b0, 1'b0);
    chk("full_ready_low", {31'd0, mv_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("full_ready_held", {30'd0, mv_ready, busy}, 32'd1);
    fin_en = 1'b1;
    push_move(6'd0, 6'd63, 1'b0, 1'b1, 1'b1);
    wait_idle();

    // Reset during WAIT of op1 with two more moves queued
    fin_delay = 5;
    exp_trig(7'd8, 1'b0, 1'b0); exp_trig(7'd16, 1'b1, 1'b0);
    outq.push_back(16'h5555);
    base = trig_seen;
    push_move(6'd8, 6'd16, 1'b0, 1'b0, 1'b0);
    push_move(6'd9, 6'd17, 1'b0, 1'b0, 1'b0);
    push_move(6'd10, 6'd18, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (trig_seen - base < 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("op1_reached", trig_seen - base, 32'd2);
    repeat (2) @(negedge clk);
    chk("in_wait_before_reset", {30'd0, nn_trigger, busy}, 32'd1);
    rst_n = 1'b0;
    sb.delete();
    outq.delete();
    #1 chk_reset_outputs("midwait_reset");
    repeat (2) @(negedge clk);
    chk_reset_outputs("midwait_hold");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_idle", {30'd0, busy, mv_ready}, 32'd1);
    chk("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
